// File: rtl/adder_pkg.sv
// adder_pkg -- shared widths and FSM state type for the multi-cycle adder.
//   IN_W      operand width (unsigned)
//   OUT_W     result width (operands zero-extended by one bit)
//   LIMB_W    width of the single reused limb adder
//   NUM_LIMBS limbs per operation (NUM_LIMBS*LIMB_W >= OUT_W)
package adder_pkg;

    localparam int IN_W      = 514;
    localparam int OUT_W     = 515;
    localparam int LIMB_W    = 64;
    localparam int NUM_LIMBS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_limb.sv
// adder_limb -- purely combinational LIMB_W-bit adder with carry in/out.
//   a, b  : limb operands
//   cin   : carry into bit 0
//   sum   : a + b + cin (low LIMB_W bits)
//   cout  : carry out of the top bit
module adder_limb
    import adder_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    logic [LIMB_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
    assign sum  = full[LIMB_W-1:0];
    assign cout = full[LIMB_W];

endmodule

// File: rtl/adder.sv
// adder -- 514-bit add/subtract computed one 64-bit limb per cycle.
//   clk       : clock, rising edge
//   resetn    : asynchronous active-low reset
//   start     : begin an operation (accepted in IDLE or DONE, ignored in RUN)
//   subtract  : 1 = A - B, 0 = A + B; sampled with start
//   in_a,in_b : unsigned operands; sampled with start
//   result    : OUT_W-bit registered sum/difference, modulo 2^OUT_W
//   done      : sticky result-valid, high 9 cycles after the start edge
// Build option: define ADDER_SUB_EN to enable subtraction; otherwise the
// subtract input is ignored and every operation adds.
module adder
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    output logic [OUT_W-1:0] result,
    output logic             done
);

    localparam int EXT_W = NUM_LIMBS * LIMB_W;
    localparam int CNT_W = $clog2(NUM_LIMBS);
    localparam int LAST  = NUM_LIMBS - 1;
    localparam int TOP_W = OUT_W - LAST * LIMB_W;   // live bits in last limb

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [EXT_W-1:0]   a_q;
    logic [EXT_W-1:0]   b_q;
    logic [LIMB_W-1:0]  sum;
    logic               cout;
    logic               sub_eff;
    logic [OUT_W-1:0]   b_ext;
    logic [OUT_W-1:0]   res_nxt;

`ifdef ADDER_SUB_EN
    assign sub_eff = subtract;
`else
    logic unused_subtract;
    assign unused_subtract = subtract;
    assign sub_eff         = 1'b0;
`endif

    // Two's-complement subtract: invert B over the full OUT_W width; the +1
    // comes from the carry register preloaded with sub_eff.
    assign b_ext = sub_eff ? ~{1'b0, in_b} : {1'b0, in_b};

    // Operands shift right one limb per cycle so the limb adder always reads
    // the low limb; the bits above OUT_W are zero padding.
    adder_limb u_limb (
        .a    (a_q[LIMB_W-1:0]),
        .b    (b_q[LIMB_W-1:0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    // Result is written in place so limb k lands at its final position on
    // the (k+1)th edge; bits of the last limb beyond OUT_W are dropped.
    always_comb begin
        res_nxt = result;
        for (int k = 0; k < LAST; k++) begin
            if (cnt == CNT_W'(k))
                res_nxt[k*LIMB_W +: LIMB_W] = sum;
        end
        if (cnt == CNT_W'(LAST))
            res_nxt[OUT_W-1:LAST*LIMB_W] = sum[TOP_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= EXT_W'(in_a);
                        b_q   <= EXT_W'(b_ext);
                        carry <= sub_eff;
                        cnt   <= '0;
                        done  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q    <= a_q >> LIMB_W;
                    b_q    <= b_q >> LIMB_W;
                    carry  <= cout;
                    result <= res_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(LAST)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder.sv
// tb_adder -- randomized scoreboard bench for adder; expected results come
// from plain wide arithmetic on the operands.
module tb_adder;
    import adder_pkg::*;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             subtract = 1'b0;
    logic [IN_W-1:0]  in_a = '0;
    logic [IN_W-1:0]  in_b = '0;
    logic [OUT_W-1:0] result;
    logic             done;

    adder dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] res;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic             done_prev = 1'b0;
    logic [OUT_W-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] a,
                                               input logic [IN_W-1:0] b,
                                               input logic s);
`ifdef ADDER_SUB_EN
        if (s) return {1'b0, a} - {1'b0, b};
`endif
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Monitor: every rising done pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && done && !done_prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done result=%h", result);
            end else begin
                e = sb.pop_front();
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL result got=%h exp=%h", result, e.res);
                end
                checks++;
                if (cyc != e.cyc + 9) begin
                    errors++;
                    $display("FAIL latency got=%0d exp=%0d", cyc - e.cyc, 9);
                end
            end
            held = result;
        end else if (resetn && done && done_prev) begin
            checks++;
            if (result !== held) begin
                errors++;
                $display("FAIL hold got=%h exp=%h", result, held);
            end
        end
        done_prev = done;
    end

    task automatic rand_op(output logic [IN_W-1:0] v);
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = 1;
            default: begin
                v = '0;
                for (int i = 0; i < 17; i++) v = {v[IN_W-33:0], $urandom()};
            end
        endcase
    endtask

    // Called just after a rising edge with the DUT not in RUN.
    task automatic issue(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic s);
        logic [IN_W-1:0] r;
        start = 1'b1; in_a = a; in_b = b; subtract = s;
        @(posedge clk); #1;
        sb.push_back('{model(a, b, s), cyc});
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_clear got=%b exp=0", done);
        end
        // Scramble inputs: must not disturb the operation in flight.
        rand_op(r); in_a = r;
        rand_op(r); in_b = r;
        subtract = ~s;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [IN_W-1:0] ones;
        logic [IN_W-1:0] ra, rb;
        int              n;
        ones = '1;

        repeat (2) @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        resetn = 1'b1;
        @(posedge clk); #1;

        issue(1, 1, 1'b0);          wait_done();
        issue(ones, ones, 1'b0);    wait_done();
        issue(1, 1, 1'b1);          wait_done();
        issue(0, 1, 1'b1);          wait_done();
        issue(2, 3, 1'b1);          wait_done();
        issue(5, 7, 1'b0);          wait_done();   // start while done=1

        // start during RUN is ignored
        issue(10, 20, 1'b0);
        repeat (3) @(posedge clk); #1;
        start = 1'b1; in_a = 99; in_b = 1; subtract = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // reset mid-RUN aborts the operation
        rand_op(ra); rand_op(rb);
        issue(ra, rb, 1'b0);
        repeat (4) @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++;
        if (result !== '0) begin errors++; $display("FAIL midrst_result got=%h exp=0", result); end
        sb.delete();
        repeat (2) @(posedge clk); #1;
        resetn = 1'b1;
        repeat (12) @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL post_rst_done got=%b exp=0", done); end
        issue(1, 1, 1'b0);          wait_done();

        for (int t = 0; t < 60; t++) begin
            rand_op(ra); rand_op(rb);
            issue(ra, rb, 1'($urandom_range(0, 1)));
            wait_done();
            n = $urandom_range(0, 2);
            repeat (n) begin @(posedge clk); #1; end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
